ex_stage: RTL
=============

Name: ex_stage

Overview:
Execute stage that sits between decode and the combinational ALU, and drives the EX/MEM boundary. It holds one decoded ALU-class instruction in an ID/EX holding register and selects the operands. It presents alu_op, alu_src1 and alu_src2 to the ALU and captures alu_result into an output register toward MEM. Both boundaries use valid/ready handshakes, and the stage resolves register hazards through optional forwarding.

Parameters:
XLEN, 64, datapath width
OPW, 15, ALU one-hot op width (bit 14 = and … bit 0 = sraw)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
flush  in  1  kill instruction in holding register
id_valid  in  1  decode offers instruction
ex_ready  out  1  stage can accept
id_alu_op  in  OPW  one-hot ALU op
id_rs1, id_rs2, id_rd  in  5  register indices
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm, id_pc  in  XLEN  immediate, PC
id_src1_pc  in  1  src1 = pc instead of rs1
id_src2_imm  in  1  src2 = imm instead of rs2
id_rf_we  in  1  writes rd
alu_op  out  OPW  to ALU
alu_src1, alu_src2  out  XLEN  to ALU
alu_result  in  XLEN  from ALU (combinational)
mem_valid  out  1  output register valid
mem_ready  in  1  MEM accepts
mem_result  out  XLEN  registered ALU result
mem_rd  out  5  destination
mem_rf_we  out  1  write enable
mem_pc  out  XLEN  PC of instruction
wb_we  in  1  writeback writes
wb_rd  in  5  writeback index
wb_data  in  XLEN  writeback data

Behaviour:
- Reset and polarity: one clock; reset is asynchronous and active-low (rst_n). On reset, ex_valid=0, mem_valid=0, mem_result=0, mem_rd=0, mem_rf_we=0, mem_pc=0. All holding-register fields clear to 0, and alu_op outputs 0.
- out_fire = mem_valid & mem_ready.
- out_free = ~mem_valid | mem_ready.
- adv = ex_valid & out_free.
- ex_ready = ~ex_valid | out_free. This is a combinational path from mem_ready.
- Accept: on id_valid & ex_ready, the holding register loads all id_* fields and ex_valid is set on the next edge.
- Advance: on adv, the output register loads alu_result, rd, rf_we and pc, and mem_valid is set. If adv occurs without a new accept, ex_valid clears.
- MEM drain: on out_fire without adv, mem_valid clears.
- Latency: accept at edge N gives mem_valid=1 after edge N+1 if MEM is not stalling. Throughput is one instruction per cycle.
- Operand select (combinational from holding register):
  - alu_src1 = src1_pc ? pc : rs1_val.
  - alu_src2 = src2_imm ? imm : rs2_val.
  - alu_op = ex_valid ? held op : 0.
- Back-pressure: with mem_ready=0 and mem_valid=1, both registers hold and ex_ready=0. Output-register contents must not change.
- Flush: clears ex_valid on the next edge and takes priority over adv for the held instruction. Flush does not affect the output register.
- Flush with accept: if id_valid & ex_ready occurs in the same cycle as flush, the new instruction is accepted and ex_valid=1.
- Reset mid-operation: both valids drop immediately. No partial result is retained.
- Scope: only ALU-class ops. Decode resolves load-use hazards by stalling.

Optional Feature:
Macro EX_FWD_EN.

Defined (forwarding on):
- Sources, in priority order: (1) the incoming instruction when id_valid & ex_ready; (2) the held instruction every cycle while ex_valid.
- For each of rs1 and rs2 with a nonzero index:
  - if mem_valid & mem_rf_we & mem_rd==rs, use mem_result;
  - else if wb_we & wb_rd==rs, use wb_data;
  - else use the register data.
- The operand mux uses the forwarded value, and the forwarded value is written back into the holding register. This keeps correctness across stalls after the producer retires.
- x0 is never forwarded.

Undefined (forwarding off):
- Holding-register data is used unchanged.
- Decode must stall until producers write back.

Test Plan:
- Reset, then id_valid=1 with op=add, rs1_data=5, imm=7, src2_imm=1 and mem_ready=1 -> mem_valid=1 two edges later, mem_result=12, and all outputs were 0 during reset.
- Back-to-back sub (10-3) then slt (-1<1) with mem_ready=1 throughout -> mem_result=7 then 1 on consecutive cycles, and ex_ready stays 1.
- Hold mem_ready=0 for 3 cycles with both registers valid -> ex_ready=0 and mem_result is stable. Then release -> the results drain in order with no loss or duplication.
- flush=1 while ex_valid=1 and mem_valid=0 -> no mem_valid next cycle. A simultaneous new accept -> only the new instruction reaches MEM.
- EX_FWD_EN: issue add x5=1+2, then add x6=x5+x5 back-to-back -> second result is 6.
- EX_FWD_EN: stall the second instruction via mem_ready=0 until the producer passes through WB -> result is still 6. With rd=0 as producer -> the register data is used.

Source files
------------

// File: rtl/ex_stage_if.sv
// ---------------------------------------------------------------------------
// ex_stage_if -- bundle of every non-clock/reset signal of the execute stage.
//
// Signal groups:
//   control   : flush
//   ID -> EX  : id_valid / ex_ready handshake plus decoded instruction fields
//               (id_alu_op, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
//               id_imm, id_pc, id_src1_pc, id_src2_imm, id_rf_we)
//   EX <-> ALU: alu_op, alu_src1, alu_src2 out; alu_result back
//   EX -> MEM : mem_valid / mem_ready handshake plus mem_result, mem_rd,
//               mem_rf_we, mem_pc
//   WB -> EX  : wb_we, wb_rd, wb_data (forwarding source)
//
// Modports:
//   slave  -- the execute stage itself
//   master -- the surrounding pipeline (decode, ALU, MEM, WB, or a bench)
// ---------------------------------------------------------------------------
interface ex_stage_if #(
    parameter int XLEN = 64,
    parameter int OPW  = 15
);
    logic            flush;

    logic            id_valid;
    logic            ex_ready;
    logic [OPW-1:0]  id_alu_op;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic            id_src1_pc;
    logic            id_src2_imm;
    logic            id_rf_we;

    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] alu_src1;
    logic [XLEN-1:0] alu_src2;
    logic [XLEN-1:0] alu_result;

    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_result;
    logic [4:0]      mem_rd;
    logic            mem_rf_we;
    logic [XLEN-1:0] mem_pc;

    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  flush,
        input  id_valid, id_alu_op, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_src1_pc, id_src2_imm, id_rf_we,
        output ex_ready,
        output alu_op, alu_src1, alu_src2,
        input  alu_result,
        output mem_valid, mem_result, mem_rd, mem_rf_we, mem_pc,
        input  mem_ready,
        input  wb_we, wb_rd, wb_data
    );

    modport master (
        output flush,
        output id_valid, id_alu_op, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_src1_pc, id_src2_imm, id_rf_we,
        input  ex_ready,
        input  alu_op, alu_src1, alu_src2,
        output alu_result,
        input  mem_valid, mem_result, mem_rd, mem_rf_we, mem_pc,
        output mem_ready,
        output wb_we, wb_rd, wb_data
    );
endinterface

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage between decode and the combinational ALU.
//
// Holds one decoded ALU-class instruction in an ID/EX holding register,
// selects the ALU operands from it, and captures the ALU result into an
// EX/MEM output register. Both boundaries use valid/ready handshakes.
//
// Ports:
//   clk    -- clock
//   rst_n  -- asynchronous active-low reset
//   bus    -- ex_stage_if.slave: flush, ID handshake and fields, ALU
//             operands/result, MEM handshake and fields, WB write port
//
// Compile-time option:
//   EX_FWD_EN -- when defined, rs1/rs2 values are forwarded from the output
//                register (MEM) and from the writeback port (WB), both when
//                an instruction is accepted and every cycle it is held. The
//                forwarded value is written back into the holding register
//                so it survives a stall that outlasts the producer.
//                When undefined, register-file data is used as delivered and
//                decode must stall until producers have written back.
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int XLEN = 64,
    parameter int OPW  = 15
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_if.slave bus
);

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            src1_pc;
        logic            src2_imm;
        logic            rf_we;
    } hold_t;

    // Holding register (ID/EX)
    logic            ex_valid;
    hold_t           hold_q;

    // Output register (EX/MEM)
    logic            mem_valid_q;
    logic [XLEN-1:0] mem_result_q;
    logic [4:0]      mem_rd_q;
    logic            mem_rf_we_q;
    logic [XLEN-1:0] mem_pc_q;

    // Handshake terms
    logic out_fire;
    logic out_free;
    logic accept;
    logic adv;

    assign out_fire = mem_valid_q & bus.mem_ready;
    assign out_free = ~mem_valid_q | bus.mem_ready;
    // Readiness does not look at flush: a flushed slot can still be refilled
    // in the same cycle. This is a combinational path from mem_ready.
    assign bus.ex_ready = ~ex_valid | out_free;
    assign accept       = bus.id_valid & bus.ex_ready;
    // A flushed instruction must never reach MEM, so flush masks advance.
    assign adv          = ex_valid & out_free & ~bus.flush;

    // ------------------------------------------------------------------
    // Operand values: forwarded or straight from the register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] id_rs1_fwd;
    logic [XLEN-1:0] id_rs2_fwd;
    logic [XLEN-1:0] ex_rs1_fwd;
    logic [XLEN-1:0] ex_rs2_fwd;

`ifdef EX_FWD_EN
    // MEM is younger than WB, so it wins. x0 is hard-wired and never forwarded.
    function automatic logic [XLEN-1:0] fwd_value(input logic [4:0]      idx,
                                                  input logic [XLEN-1:0] rf_data);
        logic [XLEN-1:0] v;
        v = rf_data;
        if (idx != 5'd0) begin
            if (mem_valid_q && mem_rf_we_q && (mem_rd_q == idx)) begin
                v = mem_result_q;
            end else if (bus.wb_we && (bus.wb_rd == idx)) begin
                v = bus.wb_data;
            end
        end
        return v;
    endfunction

    // always_comb (not assign) so reads of the MEM/WB state inside the
    // function are part of the sensitivity.
    always_comb begin
        id_rs1_fwd = fwd_value(bus.id_rs1, bus.id_rs1_data);
        id_rs2_fwd = fwd_value(bus.id_rs2, bus.id_rs2_data);
        ex_rs1_fwd = fwd_value(hold_q.rs1, hold_q.rs1_val);
        ex_rs2_fwd = fwd_value(hold_q.rs2, hold_q.rs2_val);
    end
`else
    always_comb begin
        id_rs1_fwd = bus.id_rs1_data;
        id_rs2_fwd = bus.id_rs2_data;
        ex_rs1_fwd = hold_q.rs1_val;
        ex_rs2_fwd = hold_q.rs2_val;
    end

    // Writeback port and held register indices only feed forwarding.
    logic unused_fwd;
    assign unused_fwd = ^{bus.wb_we, bus.wb_rd, bus.wb_data, hold_q.rs1, hold_q.rs2};
`endif

    // ------------------------------------------------------------------
    // Operand select toward the ALU
    // ------------------------------------------------------------------
    assign bus.alu_op   = ex_valid ? hold_q.op : '0;
    assign bus.alu_src1 = hold_q.src1_pc  ? hold_q.pc  : ex_rs1_fwd;
    assign bus.alu_src2 = hold_q.src2_imm ? hold_q.imm : ex_rs2_fwd;

    // ------------------------------------------------------------------
    // Holding register
    // ------------------------------------------------------------------
    // NOTE: every field is reset, not just the valid bit, because the
    // operand outputs are driven straight from these fields and must read
    // as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples values from before this edge.
            ex_valid <= 1'b0;
            hold_q   <= '0;
        end else if (accept) begin
            // A new accept wins over both flush and advance of the old entry.
            ex_valid        <= 1'b1;
            hold_q.op       <= bus.id_alu_op;
            hold_q.rs1      <= bus.id_rs1;
            hold_q.rs2      <= bus.id_rs2;
            hold_q.rd       <= bus.id_rd;
            hold_q.rs1_val  <= id_rs1_fwd;
            hold_q.rs2_val  <= id_rs2_fwd;
            hold_q.imm      <= bus.id_imm;
            hold_q.pc       <= bus.id_pc;
            hold_q.src1_pc  <= bus.id_src1_pc;
            hold_q.src2_imm <= bus.id_src2_imm;
            hold_q.rf_we    <= bus.id_rf_we;
        end else begin
            if (bus.flush || adv) begin
                ex_valid <= 1'b0;
            end
            // Capture forwarded operands while waiting, so the value is kept
            // after its producer has left MEM/WB. Without forwarding this
            // simply rewrites the same data.
            if (ex_valid) begin
                hold_q.rs1_val <= ex_rs1_fwd;
                hold_q.rs2_val <= ex_rs2_fwd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register toward MEM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q  <= 1'b0;
            mem_result_q <= '0;
            mem_rd_q     <= '0;
            mem_rf_we_q  <= 1'b0;
            mem_pc_q     <= '0;
        end else if (adv) begin
            mem_valid_q  <= 1'b1;
            mem_result_q <= bus.alu_result;
            mem_rd_q     <= hold_q.rd;
            mem_rf_we_q  <= hold_q.rf_we;
            mem_pc_q     <= hold_q.pc;
        end else if (out_fire) begin
            mem_valid_q  <= 1'b0;
        end
    end

    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_result = mem_result_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_rf_we  = mem_rf_we_q;
    assign bus.mem_pc     = mem_pc_q;

endmodule
